// File: rtl/pwm_duty_ramp_pkg.sv
// Shared types and constants for the PWM duty ramp block.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package pwm_duty_ramp_pkg;

  localparam int DUTY_W_DEF = 8;
  localparam int DIV_W_DEF  = 16;
  localparam int STEP_W     = 4;

  // Encoding 2'd3 is unused and is steered back to IDLE by the FSM.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ARM  = 2'd2
  } state_t;

  // A zero step would stall the ramp forever, so it is promoted to 1.
  function automatic logic [STEP_W-1:0] norm_step(input logic [STEP_W-1:0] s);
    return (s == '0) ? STEP_W'(1) : s;
  endfunction

endpackage

// File: rtl/pwm_duty_ramp_if.sv
// Target-request channel: final duty plus ramp shape, valid/ready handshake.
// Latency: n/a (wires only).
// Backpressure: producer holds tgt_valid and payload until tgt_ready.
interface pwm_duty_ramp_if
  import pwm_duty_ramp_pkg::*;
#(
  parameter int DUTY_W = DUTY_W_DEF,
  parameter int DIV_W  = DIV_W_DEF
) ();

  logic [DUTY_W-1:0] tgt_duty;
  logic [STEP_W-1:0] step_size;
  logic [DIV_W-1:0]  step_div;
  logic              tgt_valid;
  logic              tgt_ready;

  modport master (
    output tgt_duty, step_size, step_div, tgt_valid,
    input  tgt_ready
  );

  modport slave (
    input  tgt_duty, step_size, step_div, tgt_valid,
    output tgt_ready
  );

endinterface

// File: rtl/pwm_ramp_prescaler.sv
// Step-interval prescaler: counts enabled clocks, flags when count hits the divisor.
// Latency: o_tc is combinational from the registered count.
// Backpressure: none; i_en low holds the count.
module pwm_ramp_prescaler #(
  parameter int DIV_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_tc
);

  logic [DIV_W-1:0] r_cnt;

  // Counter with synchronous clear; clear wins over enable.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + DIV_W'(1);
    end
  end

  assign o_tc = (r_cnt == i_div);

endmodule

// File: rtl/pwm_duty_ramp.sv
// Slews duty_out toward an accepted target in clamped steps, one step per PWM period tick.
// Latency: first duty change >= step_div+2 clocks after accept, plus wait for period_tick.
// Backpressure: tgt_ready only in IDLE with ena high; no retarget while a ramp runs.
module pwm_duty_ramp
  import pwm_duty_ramp_pkg::*;
#(
  parameter int DUTY_W = DUTY_W_DEF,
  parameter int DIV_W  = DIV_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,   // active-high synchronous reset, legacy name
  input  logic              ena,
  pwm_duty_ramp_if.slave    tgt_if,
  input  logic              period_tick,
  output logic [DUTY_W-1:0] duty_out,
  output logic              busy,
  output logic              done
);

  state_t            r_state;
  logic [DUTY_W-1:0] r_duty;
  logic [DUTY_W-1:0] r_tgt;
  logic [STEP_W-1:0] r_step;
  logic [DIV_W-1:0]  r_div;
  logic              r_busy;
  logic              r_done;

  logic              w_accept;
  logic              w_tc;
  logic              w_up;
  logic [DUTY_W:0]   w_sum;
  logic [DUTY_W:0]   w_diff;
  logic [DUTY_W-1:0] w_next_duty;

  assign tgt_if.tgt_ready = (r_state == ST_IDLE) && ena;
  assign w_accept         = tgt_if.tgt_valid && tgt_if.tgt_ready;

  // Count only in WAIT; park at zero elsewhere so every WAIT starts from 0.
  pwm_ramp_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .i_clk (clk),
    .i_rst (rst_n),
    .i_clr (ena && (r_state != ST_WAIT)),
    .i_en  (ena && (r_state == ST_WAIT)),
    .i_div (r_div),
    .o_tc  (w_tc)
  );

  // One extra bit catches carry past full scale and borrow past zero.
  assign w_up   = (r_tgt > r_duty);
  assign w_sum  = {1'b0, r_duty} + (DUTY_W+1)'(r_step);
  assign w_diff = {1'b0, r_duty} - (DUTY_W+1)'(r_step);

  // Next duty after one step, clamped so the ramp lands exactly on the target.
  always_comb begin
    w_next_duty = r_tgt;
    if (w_up) begin
      if (w_sum < {1'b0, r_tgt}) w_next_duty = w_sum[DUTY_W-1:0];
    end else begin
      if (!w_diff[DUTY_W] && (w_diff[DUTY_W-1:0] > r_tgt)) w_next_duty = w_diff[DUTY_W-1:0];
    end
  end

  // Ramp FSM with registered duty/busy/done; ena low freezes everything.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state <= ST_IDLE;
      r_duty  <= '0;
      r_tgt   <= '0;
      r_step  <= '0;
      r_div   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (ena) begin
        case (r_state)
          ST_IDLE: begin
            if (w_accept) begin
              r_tgt  <= tgt_if.tgt_duty;
              r_step <= norm_step(tgt_if.step_size);
              r_div  <= tgt_if.step_div;
              if (tgt_if.tgt_duty == r_duty) begin
                r_done <= 1'b1;
              end else begin
                r_state <= ST_WAIT;
                r_busy  <= 1'b1;
              end
            end
          end
          ST_WAIT: begin
            if (w_tc) r_state <= ST_ARM;
          end
          ST_ARM: begin
            if (period_tick) begin
              r_duty <= w_next_duty;
              if (w_next_duty == r_tgt) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_state <= ST_WAIT;
              end
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign duty_out = r_duty;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Directed bench for pwm_duty_ramp: ramps up/down, clamping, zero step, freeze, reset.
// Latency: n/a.
// Backpressure: n/a.
module tb_pwm_duty_ramp;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       period_tick;
  logic [7:0] duty_out;
  logic       busy;
  logic       done;

  pwm_duty_ramp_if #(.DUTY_W(8), .DIV_W(16)) tif ();

  pwm_duty_ramp #(.DUTY_W(8), .DIV_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .tgt_if      (tif),
    .period_tick (period_tick),
    .duty_out    (duty_out),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int         n_checks;
  int         n_fail;
  int         cyc;
  int         acc_cyc;
  int         tick_per;
  int         done_cnt;
  int         both_hi;
  logic [7:0] prev_duty;
  logic [7:0] done_duty;
  logic [7:0] frz_duty;
  int         frz_obs;
  int         obs[$];
  int         obs_cyc[$];
  int         exp_q[$];

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One clock: sample just after the edge, log duty changes and done pulses, set next tick.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (duty_out != prev_duty) begin
      obs.push_back(int'(duty_out));
      obs_cyc.push_back(cyc);
      prev_duty = duty_out;
    end
    if (done) begin
      done_cnt++;
      done_duty = duty_out;
    end
    if (done && busy) both_hi++;
    period_tick = (tick_per > 0) && ((cyc % tick_per) == 0);
  endtask

  task automatic send(input int tgt, input int ss, input int div);
    tif.tgt_duty  = 8'(tgt);
    tif.step_size = 4'(ss);
    tif.step_div  = 16'(div);
    tif.tgt_valid = 1'b1;
    step();
    tif.tgt_valid = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < budget) begin
      step();
      n++;
    end
    if (done_cnt == d0) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic chk_obs(input string tag);
    chk({tag, "_nsteps"}, obs.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      chk($sformatf("%s_step%0d", tag, i), (i < obs.size()) ? obs[i] : -1, exp_q[i]);
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0; acc_cyc = 0; tick_per = 0;
    done_cnt = 0; both_hi = 0; prev_duty = 8'd0; done_duty = 8'd0;
    frz_duty = 8'd0; frz_obs = 0;
    period_tick = 1'b0; ena = 1'b1; rst_n = 1'b1;
    tif.tgt_valid = 1'b0; tif.tgt_duty = 8'd0; tif.step_size = 4'd0; tif.step_div = 16'd0;

    // Reset state
    step(); step();
    rst_n = 1'b0;
    chk("rst_duty", duty_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", tif.tgt_ready, 1);

    // 1: ramp up 0 -> 16 by 4, step_div 0, tick every 20 clocks
    tick_per = 20;
    obs.delete(); obs_cyc.delete();
    send(16, 4, 0);
    chk("t1_busy", busy, 1);
    wait_done(300, "t1");
    exp_q = '{4, 8, 12, 16};
    chk_obs("t1");
    chk("t1_done_duty", done_duty, 16);
    chk("t1_busy_at_done", busy, 0);
    step();
    chk("t1_done_single", done, 0);

    // 2: ramp down 16 -> 3 by 5 with step_div 3, tick every clock to expose latency
    tick_per = 1; period_tick = 1'b1;
    obs.delete(); obs_cyc.delete();
    send(3, 5, 3);
    wait_done(200, "t2");
    exp_q = '{11, 6, 3};
    chk_obs("t2");
    chk("t2_first_latency", obs_cyc[0] - acc_cyc, 5);
    chk("t2_step_gap", obs_cyc[1] - obs_cyc[0], 5);

    // 3: climb to 250, then 250 -> 255 by 8 must clamp, never wrap to 2
    send(250, 15, 0);
    wait_done(400, "t3a");
    chk("t3_at_250", duty_out, 250);
    obs.delete(); obs_cyc.delete();
    send(255, 8, 0);
    wait_done(100, "t3");
    exp_q = '{255};
    chk_obs("t3");

    // 4: target equals current duty, then step_size 0 behaves as 1
    rst_n = 1'b1; step(); rst_n = 1'b0;
    prev_duty = duty_out;
    chk("t4_rst_duty", duty_out, 0);
    send(0, 7, 2);
    chk("t4_done_next", done, 1);
    chk("t4_busy", busy, 0);
    chk("t4_duty", duty_out, 0);
    chk("t4_ready", tif.tgt_ready, 1);
    step();
    chk("t4_done_drop", done, 0);
    obs.delete(); obs_cyc.delete();
    send(2, 0, 0);
    wait_done(100, "t4");
    exp_q = '{1, 2};
    chk_obs("t4");

    // 5: no retarget mid-ramp; ena low across two ticks freezes the ramp
    tick_per = 20;
    obs.delete(); obs_cyc.delete();
    send(40, 2, 1);
    step();
    chk("t5_ready_busy", tif.tgt_ready, 0);
    tif.tgt_duty = 8'd5; tif.tgt_valid = 1'b1;
    step(); step();
    chk("t5_ready_held", tif.tgt_ready, 0);
    tif.tgt_valid = 1'b0;
    for (int n = 0; n < 200 && obs.size() < 2; n++) step();
    chk("t5_reach_6", duty_out, 6);
    ena = 1'b0;
    frz_duty = duty_out;
    frz_obs  = obs.size();
    repeat (50) step();
    chk("t5_frozen_duty", duty_out, frz_duty);
    chk("t5_frozen_nsteps", obs.size(), frz_obs);
    chk("t5_frozen_busy", busy, 1);
    chk("t5_frozen_ready", tif.tgt_ready, 0);
    ena = 1'b1;
    wait_done(1000, "t5");
    exp_q.delete();
    for (int v = 4; v <= 40; v += 2) exp_q.push_back(v);
    chk_obs("t5");
    chk("t5_final", done_duty, 40);

    // 6: reset mid-ramp at duty 12
    rst_n = 1'b1; step(); rst_n = 1'b0;
    prev_duty = duty_out;
    send(40, 4, 0);
    for (int n = 0; n < 400 && duty_out != 8'd12; n++) step();
    chk("t6_reach_12", duty_out, 12);
    rst_n = 1'b1;
    step();
    rst_n = 1'b0;
    chk("t6_duty", duty_out, 0);
    chk("t6_busy", busy, 0);
    chk("t6_ready", tif.tgt_ready, 1);
    chk("t6_done", done, 0);
    repeat (25) step();
    chk("t6_stays_idle", duty_out, 0);
    chk("t6_idle_ready", tif.tgt_ready, 1);

    chk("done_busy_overlap", both_hi, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
